// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the uart_rx_ex receiver
// Purpose: register map, CTRL/STATUS bit positions, parity encodings,
//          receive FSM state encoding and small parity helpers.
// Ports:   none (package).
package uart_pkg;

  // Register addresses on the 8-bit peripheral bus
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_DIV_LO = 3'd3;
  localparam logic [2:0] ADDR_DIV_HI = 3'd4;

  // CTRL field positions
  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_PAR_LSB = 2;
  localparam int CTRL_STOP2   = 4;
  localparam int CTRL_IE_DATA = 5;
  localparam int CTRL_IE_ERR  = 6;
  localparam logic [6:0] CTRL_RESET = 7'h03;

  // Parity encodings in CTRL[3:2]; 2'b11 behaves as no parity
  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // STATUS bit positions
  localparam int ST_DA   = 0;
  localparam int ST_OV   = 1;
  localparam int ST_FE   = 2;
  localparam int ST_PE   = 3;
  localparam int ST_FULL = 4;

  // Receive FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_odd(input logic [1:0] mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive FIFO for uart_rx_ex
// Purpose: 2**AW deep byte FIFO with combinational head output.
// Ports:   clk, reset_n  - clock, synchronous active-low reset
//          push, din     - write request and data (ignored when full unless popped)
//          pop, dout     - read request (ignored when empty) and head data
//          empty, full   - occupancy status
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ex.sv
// rtl/uart_rx_ex.sv - runtime-configurable UART receiver with FIFO and interrupt
// Purpose: samples rx with a programmable divisor and frame format, checks
//          parity/stop, queues good bytes and raises a maskable interrupt.
// Ports:   i_clk, i_reset_n          - clock, synchronous active-low reset
//          i_addr, i_dat, i_we, i_cyc - register bus (one cycle per access)
//          o_dat                     - combinational read data
//          rx                        - asynchronous serial input, idle high
//          o_int                     - registered level interrupt
module uart_rx_ex
  import uart_pkg::*;
#(
  parameter int SYS_CLK  = 25_000_000,
  parameter int BAUDRATE = 115200,
  parameter int DIV_W    = 16,
  parameter int FIFO_AW  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_dat,
  input  logic       i_we,
  input  logic       i_cyc,
  output logic [7:0] o_dat,
  input  logic       rx,
  output logic       o_int
);

  localparam int DIV_RESET = SYS_CLK / BAUDRATE;

  // Registers
  logic [6:0]       ctrl_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      div16;
  logic             ov_q, fe_q, pe_q, int_q;

  // Receiver
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]       state_q;
  logic [DIV_W-1:0] cnt_q, div_sh_q, div_eff;
  logic [4:0]       ctrl_sh_q;
  logic [2:0]       bit_q;
  logic [7:0]       data_q;
  logic             par_q, fe_pend_q, pe_pend_q, done_q;
  logic             start_edge;

  // Bus / FIFO
  logic       wr_en, pop, push, ov_set;
  logic [7:0] fifo_dout;
  logic       fifo_empty, fifo_full;

  assign div16      = 16'(div_q);
  assign div_eff    = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign start_edge = rx_prev_q & ~rx_s2_q;

  assign wr_en  = i_cyc & i_we;
  assign pop    = i_cyc & ~i_we & (i_addr == ADDR_DATA) & ~fifo_empty;
  // Completed frame is pushed the cycle after the final stop sample
  assign push   = done_q & ~fe_pend_q & ~pe_pend_q;
  assign ov_set = push & fifo_full & ~pop;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .push    (push),
    .pop     (pop),
    .din     (data_q),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Read mux
  always_comb begin
    o_dat = 8'h00;
    case (i_addr)
      ADDR_DATA:   o_dat = fifo_empty ? 8'h00 : fifo_dout;
      ADDR_STATUS: begin
        o_dat[ST_DA]   = ~fifo_empty;
        o_dat[ST_OV]   = ov_q;
        o_dat[ST_FE]   = fe_q;
        o_dat[ST_PE]   = pe_q;
        o_dat[ST_FULL] = fifo_full;
      end
      ADDR_CTRL:   o_dat = {1'b0, ctrl_q};
      ADDR_DIV_LO: o_dat = div16[7:0];
      ADDR_DIV_HI: o_dat = div16[15:8];
      default:     o_dat = 8'h00;
    endcase
  end

  // Configuration registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ctrl_q <= CTRL_RESET;
      div_q  <= DIV_W'(DIV_RESET);
    end else if (wr_en) begin
      case (i_addr)
        ADDR_CTRL:   ctrl_q <= i_dat[6:0];
        ADDR_DIV_LO: div_q  <= DIV_W'({div16[15:8], i_dat});
        ADDR_DIV_HI: div_q  <= DIV_W'({i_dat, div16[7:0]});
        default:     ;
      endcase
    end
  end

  // Sticky error flags: write-1-to-clear, a same-cycle set wins
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ov_q <= 1'b0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      if (wr_en && i_addr == ADDR_STATUS) begin
        if (i_dat[ST_OV]) ov_q <= 1'b0;
        if (i_dat[ST_FE]) fe_q <= 1'b0;
        if (i_dat[ST_PE]) pe_q <= 1'b0;
      end
      if (ov_set)              ov_q <= 1'b1;
      if (done_q && fe_pend_q) fe_q <= 1'b1;
      if (done_q && pe_pend_q) pe_q <= 1'b1;
    end
  end

  // Interrupt is computed from already-visible status, hence one cycle behind it
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      int_q <= 1'b0;
    end else begin
      int_q <= (ctrl_q[CTRL_IE_DATA] & ~fifo_empty) |
               (ctrl_q[CTRL_IE_ERR] & (ov_q | fe_q | pe_q));
    end
  end
  assign o_int = int_q;

  // Synchroniser plus previous-value flop for start-edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive FSM; format and divisor are frozen at the start edge
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_sh_q  <= DIV_W'(2);
      ctrl_sh_q <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      fe_pend_q <= 1'b0;
      pe_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start_edge) begin
          state_q   <= S_START;
          div_sh_q  <= div_eff;
          ctrl_sh_q <= ctrl_q[4:0];
          cnt_q     <= (div_eff >> 1) - DIV_W'(1);
          bit_q     <= '0;
          data_q    <= '0;
          par_q     <= 1'b0;
          fe_pend_q <= 1'b0;
          pe_pend_q <= 1'b0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end else begin
        cnt_q <= div_sh_q - DIV_W'(1);
        case (state_q)
          // High at mid-start means a glitch: drop back without recording
          S_START: state_q <= rx_s2_q ? S_IDLE : S_DATA;
          S_DATA: begin
            data_q[bit_q] <= rx_s2_q;
            par_q         <= par_q ^ rx_s2_q;
            bit_q         <= bit_q + 3'd1;
            // Last index is length code + 4 (5..8 bits)
            if (bit_q == {1'b1, ctrl_sh_q[CTRL_LEN_LSB +: 2]}) begin
              state_q <= parity_en(ctrl_sh_q[CTRL_PAR_LSB +: 2]) ? S_PARITY : S_STOP1;
            end
          end
          S_PARITY: begin
            pe_pend_q <= par_q ^ rx_s2_q ^ parity_odd(ctrl_sh_q[CTRL_PAR_LSB +: 2]);
            state_q   <= S_STOP1;
          end
          S_STOP1: begin
            fe_pend_q <= ~rx_s2_q;
            if (ctrl_sh_q[CTRL_STOP2]) begin
              state_q <= S_STOP2;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_STOP2: begin
            fe_pend_q <= fe_pend_q | ~rx_s2_q;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ex.sv
// tb/tb_uart_rx_ex.sv - scoreboard testbench for uart_rx_ex
module tb_uart_rx_ex;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdat = 8'h00;
  logic       we = 1'b0;
  logic       cyc = 1'b0;
  logic [7:0] rdat;
  logic       rx = 1'b1;
  logic       irq;

  uart_rx_ex #(
    .SYS_CLK  (25_000_000),
    .BAUDRATE (115200),
    .DIV_W    (16),
    .FIFO_AW  (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rstn),
    .i_addr    (addr),
    .i_dat     (wdat),
    .i_we      (we),
    .i_cyc     (cyc),
    .o_dat     (rdat),
    .rx        (rx),
    .o_int     (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] exp_q [$];
  bit         m_ov, m_fe, m_pe;
  logic [7:0] m_ctrl = 8'h03;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] status_exp();
    return {3'b000, exp_q.size() == DEPTH, m_pe, m_fe, m_ov, exp_q.size() != 0};
  endfunction

  function automatic logic [7:0] int_exp();
    return 8'((m_ctrl[5] && exp_q.size() != 0) || (m_ctrl[6] && (m_ov || m_fe || m_pe)));
  endfunction

  // Monitor: every DATA read pops the scoreboard (or expects 0 when empty)
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (rstn && cyc && !we && addr == 3'd0) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else mon_exp = 8'h00;
      check("data", rdat, mon_exp);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdat = d; we = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    addr = a; we = 1'b0; cyc = 1'b1;
    @(negedge clk);
    d = rdat;
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  task automatic drain();
    logic [7:0] v;
    for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) bus_read(3'd0, v);
  endtask

  // Serial driver; ctrl decoded with the CTRL field rules
  task automatic drive_frame(input logic [7:0] b, input logic [7:0] ctrl,
                             input bit bad_par, input bit bad_stop, input int bitlen);
    int   nbits, stops, ones;
    logic [1:0] pm;
    logic [7:0] mask;
    logic pbit;
    nbits = int'(ctrl[1:0]) + 5;
    pm    = ctrl[3:2];
    stops = ctrl[4] ? 2 : 1;
    mask  = 8'hFF >> (8 - nbits);
    ones  = $countones(b & mask);
    pbit  = (pm == 2'b10) ? ~ones[0] : ones[0];
    if (bad_par) pbit = ~pbit;
    @(posedge clk); #1;
    rx = 1'b0;
    wait_cyc(bitlen);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      wait_cyc(bitlen);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      rx = pbit;
      wait_cyc(bitlen);
    end
    for (int s = 0; s < stops; s++) begin
      rx = (bad_stop && s == stops - 1) ? 1'b0 : 1'b1;
      wait_cyc(bitlen);
    end
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic [7:0] ctrl,
                             input bit bad_par, input bit bad_stop);
    logic [7:0] mask;
    bit par_on;
    mask   = 8'hFF >> (3 - int'(ctrl[1:0]));
    par_on = (ctrl[3:2] == 2'b01) || (ctrl[3:2] == 2'b10);
    if (bad_stop) m_fe = 1'b1;
    else if (bad_par && par_on) m_pe = 1'b1;
    else if (exp_q.size() == DEPTH) m_ov = 1'b1;
    else exp_q.push_back(b & mask);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [7:0] ctrl,
                            input bit bad_par, input bit bad_stop, input int bitlen);
    drive_frame(b, ctrl, bad_par, bad_stop, bitlen);
    model_frame(b, ctrl, bad_par, bad_stop);
  endtask

  task automatic set_ctrl(input logic [7:0] c);
    bus_write(3'd2, c);
    m_ctrl = c & 8'h7F;
  endtask

  task automatic clear_flags();
    bus_write(3'd1, 8'h0E);
    m_ov = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
  endtask

  initial begin
    #1_500_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v, c, b;
    bit bp;

    wait_cyc(3);
    rstn = 1'b1;
    wait_cyc(2);

    // Reset state
    check_reg("rst_status", 3'd1, 8'h00);
    check_reg("rst_ctrl", 3'd2, 8'h03);
    check_reg("rst_div_lo", 3'd3, 8'd217);
    check_reg("rst_div_hi", 3'd4, 8'h00);
    check_reg("rst_addr5", 3'd5, 8'h00);
    check("rst_int", 8'(irq), 8'h00);
    bus_read(3'd0, v);

    // 8N1 0xA5, interrupt only when IE_DATA set
    send_frame(8'hA5, 8'h03, 1'b0, 1'b0, 217);
    wait_cyc(4);
    check_reg("a5_status", 3'd1, status_exp());
    check("a5_int_off", 8'(irq), int_exp());
    set_ctrl(8'h23);
    wait_cyc(3);
    check("a5_int_on", 8'(irq), int_exp());
    bus_read(3'd0, v);
    check_reg("a5_status_after", 3'd1, status_exp());
    wait_cyc(3);
    check("a5_int_clear", 8'(irq), int_exp());

    // 7E1: good parity then bad parity with IE_ERR
    set_ctrl(8'h46);
    send_frame(8'h41, 8'h46, 1'b0, 1'b0, 217);
    wait_cyc(4);
    drain();
    send_frame(8'h41, 8'h46, 1'b1, 1'b0, 217);
    wait_cyc(4);
    check_reg("pe_status", 3'd1, status_exp());
    check("pe_int", 8'(irq), int_exp());
    bus_write(3'd1, 8'h08);
    m_pe = 1'b0;
    check_reg("pe_cleared", 3'd1, status_exp());
    wait_cyc(3);
    check("pe_int_clear", 8'(irq), int_exp());

    // Start glitch followed promptly by a real frame
    set_ctrl(8'h03);
    @(posedge clk); #1;
    rx = 1'b0;
    wait_cyc(50);
    rx = 1'b1;
    wait_cyc(70);
    check_reg("glitch_status", 3'd1, status_exp());
    send_frame(8'h96, 8'h03, 1'b0, 1'b0, 217);
    wait_cyc(4);
    drain();

    // 8N2 with bad second stop bit
    set_ctrl(8'h13);
    send_frame(8'h5A, 8'h13, 1'b0, 1'b1, 217);
    wait_cyc(4);
    check_reg("fe_status", 3'd1, status_exp());
    bus_write(3'd1, 8'h04);
    m_fe = 1'b0;
    check_reg("fe_cleared", 3'd1, status_exp());

    // Divisor written mid-frame applies to the next frame only
    set_ctrl(8'h03);
    fork
      send_frame(8'h3C, 8'h03, 1'b0, 1'b0, 217);
      begin
        wait_cyc(600);
        bus_write(3'd3, 8'd54);
      end
    join
    send_frame(8'hC3, 8'h03, 1'b0, 1'b0, 54);
    wait_cyc(4);
    check_reg("div54", 3'd3, 8'd54);
    drain();

    // Divisor 1 behaves as 2
    bus_write(3'd3, 8'd1);
    check_reg("div1", 3'd3, 8'd1);
    send_frame(8'h5A, 8'h03, 1'b0, 1'b0, 2);
    wait_cyc(4);
    drain();
    bus_write(3'd3, 8'd54);

    // 17 back-to-back bytes: full plus overflow
    for (int i = 0; i < 17; i++) send_frame(8'(i), 8'h03, 1'b0, 1'b0, 54);
    wait_cyc(4);
    check_reg("ovf_status", 3'd1, status_exp());
    drain();
    check_reg("ovf_drained", 3'd1, status_exp());
    clear_flags();
    check_reg("ovf_cleared", 3'd1, status_exp());

    // Randomized formats and bytes
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      c = 8'($urandom_range(0, 31));
      bp = (c[3:2] == 2'b01 || c[3:2] == 2'b10) && ($urandom_range(0, 2) == 0);
      set_ctrl(c);
      send_frame(b, c, bp, 1'b0, 54);
      wait_cyc(4);
      check_reg("rand_status", 3'd1, status_exp());
      drain();
      clear_flags();
    end

    // Reset mid-frame with 3 bytes queued and FE pending
    set_ctrl(8'h03);
    send_frame(8'h11, 8'h03, 1'b0, 1'b0, 54);
    send_frame(8'h22, 8'h03, 1'b0, 1'b0, 54);
    send_frame(8'h33, 8'h03, 1'b0, 1'b0, 54);
    send_frame(8'h44, 8'h03, 1'b0, 1'b1, 54);
    wait_cyc(4);
    check_reg("pre_rst_status", 3'd1, status_exp());
    fork
      drive_frame(8'hFF, 8'h03, 1'b0, 1'b0, 54);
      begin
        wait_cyc(54 * 4);
        rstn = 1'b0;
        wait_cyc(1);
        rstn = 1'b1;
        exp_q.delete();
        m_ov = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
        m_ctrl = 8'h03;
      end
    join
    wait_cyc(4);
    check_reg("mrst_status", 3'd1, status_exp());
    check_reg("mrst_ctrl", 3'd2, 8'h03);
    check_reg("mrst_div_lo", 3'd3, 8'd217);
    check("mrst_int", 8'(irq), 8'h00);
    bus_read(3'd0, v);
    send_frame(8'h77, 8'h03, 1'b0, 1'b0, 217);
    wait_cyc(4);
    check_reg("post_rst_status", 3'd1, status_exp());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
